cipher_round_sequencer: RTL and testbench
=========================================

Name: cipher_round_sequencer

Overview:
Top-level sequencer for the 128-bit block cipher core. Accepts one key+block per transaction over a valid/ready handshake and pulses the key schedule's reset. Drives the shared 4-bit sub-cycle counter and encrypt flag to the key schedule and the round datapath, and holds the working block register, updating it once per round. Presents the result over a valid/ready output handshake.

Parameters:
NUM_ROUNDS, 10, number of datapath rounds per block (1..15).
WARM_PERIODS, 2, 16-cycle periods the key schedule needs before the first round key is valid (0..3).

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  synchronous, active-high
in_valid  input  1  request carries key/block/encrypt
in_ready  output  1  sequencer idle, accepts request
in_encrypt  input  1  1=encrypt, 0=decrypt
in_key  input  128  cipher key
in_block  input  128  plaintext/ciphertext
ks_reset  output  1  key schedule reset pulse
ks_key  output  128  latched key to key schedule
ks_encrypt  output  1  latched direction
counter  output  4  sub-cycle counter to key schedule and datapath
rf_block  output  128  working block to round datapath
rf_result  input  128  round datapath output for rf_block
rf_last  output  1  current round is final round
round_idx  output  4  current round number
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_block  output  128  result block (= working register)
busy  output  1  state != IDLE

Behaviour:
- States: IDLE, KS_INIT, WARM, RUN, DONE.
- Reset (any state, mid-operation included) -> IDLE. Outputs on reset: counter=0, round_idx=0, working register=0, key/encrypt latches=0, out_valid=0, ks_reset=0, in_ready=1.
- IDLE: in_ready=1. On in_valid: latch in_key, in_block, in_encrypt, then go to KS_INIT.
- KS_INIT: exactly one cycle. ks_reset=1 only here. counter=0. Next state: WARM, or RUN if WARM_PERIODS=0.
- WARM: counter increments every clk 0..15 and wraps. Leave after WARM_PERIODS wraps, on the cycle where counter==15 -> RUN.
- RUN: counter keeps cycling. On each counter==15 cycle, working register <= rf_result.
  - If round_idx == NUM_ROUNDS-1 -> DONE, round_idx held.
  - Otherwise round_idx increments.
- rf_last=1 in RUN while round_idx==NUM_ROUNDS-1.
- DONE: out_valid=1 and counter=0. Hold out_block until out_ready, then go to IDLE.
- Latency: out_valid rises exactly 1+16*(WARM_PERIODS+NUM_ROUNDS) clocks after the accepting edge; 193 with defaults.
- Handshake rules:
  - in_valid outside IDLE is ignored; in_ready=0.
  - out_ready without out_valid is ignored.
  - out_valid never drops without out_ready.
  - In DONE with out_ready, in_ready is still 0 that cycle; there is no bypass. The next accept is at earliest the following cycle.
- Inputs are sampled only at accept; in_key/in_block changes afterwards have no effect.
- counter is 4-bit and wraps 15->0 naturally. round_idx never exceeds NUM_ROUNDS-1.

Optional Feature:
Macro CIPHER_SEQ_STALL_EN.
- Defined: adds input port stall (1 bit). While stall=1 in WARM/RUN, counter, round_idx, state and working register all freeze; they resume on the next unstalled cycle. stall is ignored in IDLE/KS_INIT/DONE. Latency grows by exactly the number of stalled WARM/RUN cycles.
- Undefined: port absent; behaviour as above.

Decomposition:
- Shared package cipher_ctrl_pkg:
  - state encoding constants (S_IDLE..S_DONE)
  - SUBCYCLE_LAST=4'hf
  - BLOCK_W=128, KEY_W=128
  - default NUM_ROUNDS/WARM_PERIODS
- One sub-module: subcycle_counter. 4-bit counter with enable and clear; outputs the count and a wrap flag (count==15 & enable).

Test Plan:
- Basic, with stub datapath rf_result=rf_block+1: accept in_block=128'h0, defaults -> out_valid at accept+193, out_block=128'hA, ks_reset high exactly 1 cycle at accept+1.
- Output backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_block stable at 128'hA, in_ready=0 throughout; out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-RUN at round_idx=5 -> next cycle IDLE, counter=0, out_valid=0; a new request then completes in 193 cycles with a correct result.
- in_valid pulsed during RUN with in_block=128'hFF -> ignored; final out_block still reflects the first request.
- Parameters NUM_ROUNDS=3, WARM_PERIODS=0 -> latency 49, out_block=in_block+3, rf_last high exactly 16 cycles.
- With CIPHER_SEQ_STALL_EN: stall=1 for 7 cycles in RUN -> latency 200, out_block unchanged at 128'hA.

Source files
------------

// File: rtl/cipher_ctrl_pkg.sv
// Purpose: shared types and constants for the block cipher control path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cipher_ctrl_pkg;

  localparam int BLOCK_W          = 128;
  localparam int KEY_W            = 128;
  localparam int DEF_NUM_ROUNDS   = 10;
  localparam int DEF_WARM_PERIODS = 2;

  // Last value of the 16-step sub-cycle; one round or warm period ends here.
  localparam logic [3:0] SUBCYCLE_LAST = 4'hf;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_KS_INIT = 3'd1,
    S_WARM    = 3'd2,
    S_RUN     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/cipher_round_sequencer_subcycle.sv
// Purpose: 4-bit sub-cycle counter with enable and clear, plus end-of-cycle flag.
// Latency: count updates one clock after en/clear; wrap is combinational.
// Backpressure: none; deasserting en freezes the count.
// Ports: clk, reset (sync, active-high), en, clear -> count[3:0], wrap.
module subcycle_counter
  import cipher_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clear,
  output logic [3:0] count,
  output logic       wrap
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= 4'd0;
    end else if (en) begin
      count <= count + 4'd1;  // 15 -> 0 wraps naturally
    end
  end

  assign wrap = en && (count == SUBCYCLE_LAST);

endmodule

// File: rtl/cipher_round_sequencer.sv
// Purpose: sequences key-schedule warm-up and NUM_ROUNDS datapath rounds per block.
// Latency: out_valid 1+16*(WARM_PERIODS+NUM_ROUNDS) clocks after accept (+ stalled cycles).
// Backpressure: one block in flight; in_ready low until result drained by out_ready.
// Ports: clk/reset; in_* request handshake; ks_* key schedule control; counter,
//   rf_block/rf_result/rf_last/round_idx to the round datapath; out_* result
//   handshake; busy. Optional stall input when CIPHER_SEQ_STALL_EN is defined.
module cipher_round_sequencer
  import cipher_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS   = DEF_NUM_ROUNDS,
  parameter int WARM_PERIODS = DEF_WARM_PERIODS
) (
  input  logic               clk,
  input  logic               reset,
`ifdef CIPHER_SEQ_STALL_EN
  input  logic               stall,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_encrypt,
  input  logic [KEY_W-1:0]   in_key,
  input  logic [BLOCK_W-1:0] in_block,
  output logic               ks_reset,
  output logic [KEY_W-1:0]   ks_key,
  output logic               ks_encrypt,
  output logic [3:0]         counter,
  output logic [BLOCK_W-1:0] rf_block,
  input  logic [BLOCK_W-1:0] rf_result,
  output logic               rf_last,
  output logic [3:0]         round_idx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_block,
  output logic               busy
);

  localparam logic [3:0] ROUND_LAST = 4'(NUM_ROUNDS - 1);
  localparam logic [1:0] WARM_LAST  = 2'((WARM_PERIODS > 0) ? WARM_PERIODS - 1 : 0);

  state_t               state, state_nxt;
  logic [BLOCK_W-1:0]   work;
  logic [1:0]           warm_cnt;
  logic                 hold;
  logic                 cnt_active;
  logic                 cnt_en;
  logic                 wrap;

`ifdef CIPHER_SEQ_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  // Counter only runs in WARM/RUN; everywhere else it is held at 0, so
  // KS_INIT and DONE both present counter=0.
  assign cnt_active = (state == S_WARM) || (state == S_RUN);
  assign cnt_en     = cnt_active && !hold;

  subcycle_counter u_subcycle (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_en),
    .clear (!cnt_active),
    .count (counter),
    .wrap  (wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // wrap already includes the stall gate, so a stalled cycle cannot advance state.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (in_valid) state_nxt = S_KS_INIT;
      S_KS_INIT: state_nxt = (WARM_PERIODS == 0) ? S_RUN : S_WARM;
      S_WARM:    if (wrap && (warm_cnt == WARM_LAST)) state_nxt = S_RUN;
      S_RUN:     if (wrap && (round_idx == ROUND_LAST)) state_nxt = S_DONE;
      S_DONE:    if (out_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      work       <= '0;
      ks_key     <= '0;
      ks_encrypt <= 1'b0;
      round_idx  <= 4'd0;
      warm_cnt   <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            work       <= in_block;
            ks_key     <= in_key;
            ks_encrypt <= in_encrypt;
            round_idx  <= 4'd0;
            warm_cnt   <= 2'd0;
          end
        end
        S_WARM: begin
          if (wrap) warm_cnt <= warm_cnt + 2'd1;
        end
        S_RUN: begin
          if (wrap) begin
            work <= rf_result;
            // Final round: index stays put so rf_last/round_idx stay in range.
            if (round_idx != ROUND_LAST) round_idx <= round_idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign ks_reset  = (state == S_KS_INIT);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign rf_last   = (state == S_RUN) && (round_idx == ROUND_LAST);
  assign rf_block  = work;
  assign out_block = work;

endmodule

// File: tb/tb_cipher_round_sequencer.sv
module tb_cipher_round_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         sel;
  logic         in_valid, in_encrypt, out_ready;
  logic [127:0] in_key, in_block;
`ifdef CIPHER_SEQ_STALL_EN
  logic         stall;
`endif

  // DUT A: default parameters. DUT B: NUM_ROUNDS=3, WARM_PERIODS=0.
  logic         a_in_ready, a_ks_reset, a_ks_encrypt, a_rf_last, a_out_valid, a_busy;
  logic [127:0] a_ks_key, a_rf_block, a_out_block;
  logic [3:0]   a_counter, a_round_idx;
  logic         b_in_ready, b_ks_reset, b_ks_encrypt, b_rf_last, b_out_valid, b_busy;
  logic [127:0] b_ks_key, b_rf_block, b_out_block;
  logic [3:0]   b_counter, b_round_idx;

  cipher_round_sequencer u_dut_a (
    .clk(clk), .reset(reset),
`ifdef CIPHER_SEQ_STALL_EN
    .stall(stall & ~sel),
`endif
    .in_valid(in_valid & ~sel), .in_ready(a_in_ready), .in_encrypt(in_encrypt),
    .in_key(in_key), .in_block(in_block), .ks_reset(a_ks_reset), .ks_key(a_ks_key),
    .ks_encrypt(a_ks_encrypt), .counter(a_counter), .rf_block(a_rf_block),
    .rf_result(a_rf_block + 128'd1), .rf_last(a_rf_last), .round_idx(a_round_idx),
    .out_valid(a_out_valid), .out_ready(out_ready & ~sel), .out_block(a_out_block),
    .busy(a_busy)
  );

  cipher_round_sequencer #(.NUM_ROUNDS(3), .WARM_PERIODS(0)) u_dut_b (
    .clk(clk), .reset(reset),
`ifdef CIPHER_SEQ_STALL_EN
    .stall(stall & sel),
`endif
    .in_valid(in_valid & sel), .in_ready(b_in_ready), .in_encrypt(in_encrypt),
    .in_key(in_key), .in_block(in_block), .ks_reset(b_ks_reset), .ks_key(b_ks_key),
    .ks_encrypt(b_ks_encrypt), .counter(b_counter), .rf_block(b_rf_block),
    .rf_result(b_rf_block + 128'd1), .rf_last(b_rf_last), .round_idx(b_round_idx),
    .out_valid(b_out_valid), .out_ready(out_ready & sel), .out_block(b_out_block),
    .busy(b_busy)
  );

  // View of whichever DUT is selected.
  logic         c_in_ready, c_ks_reset, c_ks_encrypt, c_rf_last, c_out_valid, c_busy;
  logic [127:0] c_ks_key, c_out_block;
  logic [3:0]   c_counter, c_round_idx;
  assign c_in_ready   = sel ? b_in_ready   : a_in_ready;
  assign c_ks_reset   = sel ? b_ks_reset   : a_ks_reset;
  assign c_ks_encrypt = sel ? b_ks_encrypt : a_ks_encrypt;
  assign c_rf_last    = sel ? b_rf_last    : a_rf_last;
  assign c_out_valid  = sel ? b_out_valid  : a_out_valid;
  assign c_busy       = sel ? b_busy       : a_busy;
  assign c_ks_key     = sel ? b_ks_key     : a_ks_key;
  assign c_out_block  = sel ? b_out_block  : a_out_block;
  assign c_counter    = sel ? b_counter    : a_counter;
  assign c_round_idx  = sel ? b_round_idx  : a_round_idx;

  typedef struct {
    bit           sel;
    logic [127:0] blk;
    int           hold;
    int           inj_at;
    int           stall_at;
    logic [127:0] exp_blk;
    int           exp_lat;
    int           exp_rflast;
    int           exp_maxr;
  } vec_t;

  vec_t         vecs[5];
  logic [127:0] sb_q[$];
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input vec_t v);
    logic [127:0] key, blk0, exp;
    logic         enc;
    int           w, cyc, ksr_cnt, ksr_first, rfl, maxr, bad;
    sel = v.sel;
    w = 0;
    while (!c_in_ready && w < 10) begin tick(); w++; end
    check("in_ready before accept", c_in_ready, 1);
    key = {$urandom, $urandom, $urandom, $urandom};
    enc = 1'($urandom_range(0, 1));
    in_valid = 1'b1; in_key = key; in_block = v.blk; in_encrypt = enc;
    sb_q.push_back(v.exp_blk);
    tick();
    // Post-accept input changes must not reach the latches.
    in_valid = 1'b0; in_key = ~key; in_block = ~v.blk; in_encrypt = ~enc;
    cyc = 0; ksr_cnt = 0; ksr_first = -1; rfl = 0; maxr = 0;
    while (!c_out_valid && cyc < 400) begin
      if (c_ks_reset) begin
        ksr_cnt++;
        if (ksr_first < 0) ksr_first = cyc;
      end
      if (c_rf_last) rfl++;
      if (int'(c_round_idx) > maxr) maxr = int'(c_round_idx);
      if (v.inj_at > 0 && cyc == v.inj_at) begin
        check("in_ready while busy", c_in_ready, 0);
        in_valid = 1'b1; in_block = 128'hFF;
      end else begin
        in_valid = 1'b0;
      end
`ifdef CIPHER_SEQ_STALL_EN
      stall = (v.stall_at > 0 && cyc >= v.stall_at && cyc < v.stall_at + 7);
`endif
      tick();
      cyc++;
    end
    in_valid = 1'b0;
`ifdef CIPHER_SEQ_STALL_EN
    stall = 1'b0;
`endif
    check("latency", cyc, v.exp_lat);
    check("ks_reset pulse count", ksr_cnt, 1);
    check("ks_reset pulse cycle", ksr_first, 0);
    check("rf_last cycles", rfl, v.exp_rflast);
    check("max round_idx", maxr, v.exp_maxr);
    check("ks_key latched", c_ks_key, key);
    check("ks_encrypt latched", c_ks_encrypt, enc);
    check("counter in DONE", c_counter, 0);
    out_ready = 1'b0;
    blk0 = c_out_block;
    bad = 0;
    for (int i = 0; i < v.hold; i++) begin
      tick();
      if (c_out_block !== blk0 || c_in_ready !== 1'b0 || c_out_valid !== 1'b1) bad++;
    end
    if (v.hold > 0) check("backpressure hold violations", bad, 0);
    if (sb_q.size() == 0) begin
      check("scoreboard underflow", 1, 0);
      exp = '0;
    end else begin
      exp = sb_q.pop_front();
    end
    check("out_block", c_out_block, exp);
    out_ready = 1'b1;
    check("in_ready during drain", c_in_ready, 0);
    tick();
    out_ready = 1'b0;
    check("in_ready after drain", c_in_ready, 1);
    check("out_valid after drain", c_out_valid, 0);
    check("busy after drain", c_busy, 0);
  endtask

  initial begin
    int w;
    vecs[0] = '{1'b0, 128'h0, 20, 0, 0, 128'hA, 193, 16, 9};
    vecs[1] = '{1'b0, 128'h5, 0, 100, 0, 128'hF, 193, 16, 9};
    vecs[2] = '{1'b0, {128{1'b1}}, 0, 0, 0, 128'h9, 193, 16, 9};
    vecs[3] = '{1'b1, 128'h77, 2, 20, 0, 128'h7A, 49, 16, 2};
    vecs[4] = '{1'b1, {{127{1'b1}}, 1'b0}, 0, 0, 0, 128'h1, 49, 16, 2};

    reset = 1'b1; sel = 1'b0; in_valid = 1'b0; in_encrypt = 1'b0; out_ready = 1'b0;
    in_key = '0; in_block = '0;
`ifdef CIPHER_SEQ_STALL_EN
    stall = 1'b0;
`endif
    tick(); tick();
    check("reset in_ready", a_in_ready, 1);
    check("reset out_valid", a_out_valid, 0);
    check("reset ks_reset", a_ks_reset, 0);
    check("reset counter", a_counter, 0);
    check("reset round_idx", a_round_idx, 0);
    check("reset out_block", a_out_block, 0);
    check("reset ks_key", a_ks_key, 0);
    check("reset ks_encrypt", a_ks_encrypt, 0);
    check("reset busy", a_busy, 0);
    reset = 1'b0;
    tick();

    // Abort mid-RUN at round 5; this request is never scoreboarded.
    sel = 1'b0;
    in_valid = 1'b1; in_key = {4{32'hDEADBEEF}}; in_block = 128'h3; in_encrypt = 1'b1;
    tick();
    in_valid = 1'b0;
    w = 0;
    while (a_round_idx != 4'd5 && w < 500) begin tick(); w++; end
    check("reached round 5", a_round_idx, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid-run reset in_ready", a_in_ready, 1);
    check("mid-run reset counter", a_counter, 0);
    check("mid-run reset out_valid", a_out_valid, 0);
    check("mid-run reset round_idx", a_round_idx, 0);
    check("mid-run reset out_block", a_out_block, 0);
    check("mid-run reset ks_key", a_ks_key, 0);

    for (int i = 0; i < 5; i++) do_txn(vecs[i]);

`ifdef CIPHER_SEQ_STALL_EN
    begin
      vec_t sv;
      sv = '{1'b0, 128'h0, 0, 0, 50, 128'hA, 200, 16, 9};
      do_txn(sv);
    end
`endif

    check("scoreboard empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
